dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipeline's MEM-stage load/store requests. It accepts one request
//  at a time over a valid/ready handshake, inserts programmable wait states, performs byte-lane
//  store merging or load extraction with sign/zero extension (RV64I widths), and returns a response.
// PARAMETERS
//  DEPTH        512  storage size in 64-bit doublewords (power of 2); localparam IDX_W = $clog2(DEPTH)
//  WAIT_STATES  0    extra cycles between accept and response (0..15)
// PORTS
//  clk         in   1   clock, all state on posedge
//  rst         in   1   reset, asynchronous, active-low (0 = in reset)
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; transfer when req_valid & req_ready
//  req_we      in   1   1 = store, 0 = load
//  req_addr    in   64  byte address
//  req_funct3  in   3   RV64I funct3: load 000 LB,001 LH,010 LW,011 LD,100 LBU,101 LHU,110 LWU; store 000..011
//  req_wdata   in   64  store data, right-justified
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   consumer accepts; transfer when rsp_valid & rsp_ready
//  rsp_rdata   out  64  extended load data; 0 for stores and errors
//  rsp_err     out  1   illegal funct3 or (macro on) misaligned access
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  - FSM IDLE -> (accept) -> WAIT (if WAIT_STATES>0) -> RESP -> (rsp_ready) -> IDLE.
//  - req_ready = (state==IDLE) & rst; no accept outside IDLE; one outstanding request max.
//  - Request fields captured on the accept edge; later changes on req_* are ignored.
//  - WAIT: counter loaded with WAIT_STATES-1 at accept, decrements, exits at 0.
//  - Latency: rsp_valid rises exactly 1+WAIT_STATES cycles after the accept edge.
//  - Storage access happens on the edge entering RESP: stores merge enabled bytes; loads register data.
//  - Index = addr[IDX_W+2:3]; upper address bits ignored (addresses wrap modulo DEPTH*8).
//  - Byte lanes: addr[2:0] selects lowest lane; size 1/2/4/8 bytes from funct3[1:0].
//  - Load extension: funct3[2]=0 sign-extend from top byte of size, funct3[2]=1 zero-extend.
//  - Illegal: store with funct3[2]=1, load funct3=111 -> rsp_err=1, rsp_rdata=0, no write.
//  - RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_ready; rsp_ready while not rsp_valid ignored.
//  - Reset (rst low, any time): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0;
//    in-flight request dropped; a store not yet at the RESP edge is never written. Storage not cleared.
// CONFIGURATION
//  DMEM_MISALIGN_ERR_EN defined: access with addr[2:0] not a multiple of size -> rsp_err=1,
//    rsp_rdata=0, no write, same latency.
//  Undefined: addr low bits below size granularity forced to 0 (naturally aligned access), rsp_err
//    only for illegal funct3.
// STRUCTURE
//  dmem_pkg: state enum {IDLE,WAIT,RESP}; funct3 size localparams (F3_B/H/W/D, F3_BU/HU/WU);
//    function size_bytes(funct3).
//  Sub-module dmem_lane_align (combinational): byte-enable + shifted wdata for stores,
//    lane extract + extension for loads, misalignment flag.
// TESTING
//  1 rst low 3 cycles mid-idle -> all outputs 0; release -> req_ready=1 next cycle, busy=0.
//  2 WAIT_STATES=0: SD 0x1122334455667788 @0x40, then LD @0x40 -> rdata 0x1122334455667788,
//    err=0, rsp_valid 1 cycle after each accept.
//  3 SB 0xAB @0x43; LB @0x43 -> 0xFFFFFFFFFFFFFFAB; LBU @0x43 -> 0xAB; LD @0x40 -> 0x11223344AB667788.
//  4 WAIT_STATES=3: LW @0x40 -> rsp_valid 4 cycles after accept, rdata 0x0000000055667788; hold
//    rsp_ready=0 5 cycles -> rdata stable, req_ready=0, busy=1.
//  5 LW @0x42: macro on -> err=1 rdata=0; macro off -> rdata 0x0000000055667788. Store funct3=100 -> err=1, memory unchanged.
//  6 DEPTH=512: SD 0xDEAD @0x1000 then LD @0x0 -> 0xDEAD; SD 0xBEEF @0x0 with rst pulsed low
//    during WAIT (WAIT_STATES=2) -> later LD @0x0 -> 0xDEAD.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, RV64I load/store funct3 codes and an
// access-size helper for the data-memory responder.
package dmem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // RV64I funct3 encodings (stores use only the signed-width codes 000..011)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access size in bytes; only the low two funct3 bits encode the width
  function automatic logic [3:0] size_bytes(input logic [1:0] f3_size);
    logic [3:0] sz;
    case (f3_size)
      2'd0:    sz = 4'd1;
      2'd1:    sz = 4'd2;
      2'd2:    sz = 4'd4;
      default: sz = 4'd8;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one 64-bit doubleword.
// Stores: byte enables plus write data shifted into the addressed lanes.
// Loads: addressed lanes shifted down and sign/zero extended per funct3.
// Also flags a misaligned address and an illegal funct3.
// Optional feature macro DMEM_MISALIGN_ERR_EN: when defined the raw address
// offset is used (misaligned accesses are rejected upstream); when undefined
// offset bits below the access size are cleared so accesses are naturally aligned.
import dmem_pkg::*;

module dmem_lane_align (
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [2:0]  addr_lo_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdword_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [3:0]  size;
  logic [2:0]  lane_mask;
  logic [7:0]  be_base;
  logic [2:0]  offset;
  logic [63:0] ld_shift;

  assign size      = size_bytes(funct3_i[1:0]);
  assign lane_mask = 3'(size - 4'd1);
  assign be_base   = 8'((9'd1 << size) - 9'd1);

`ifdef DMEM_MISALIGN_ERR_EN
  assign offset = addr_lo_i;
`else
  assign offset = addr_lo_i & ~lane_mask;
`endif

  assign misalign_o = |(addr_lo_i & lane_mask);
  assign be_o       = be_base << offset;
  assign wdata_o    = wdata_i << {offset, 3'b000};
  assign ld_shift   = rdword_i >> {offset, 3'b000};

  // Stores have no unsigned variants; LDU (111) does not exist in RV64I
  assign illegal_o = we_i ? funct3_i[2] : (funct3_i == 3'b111);

  // Extract the addressed field and extend it to 64 bits
  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{56{ld_shift[7]}}, ld_shift[7:0]};
      F3_BU:   rdata_o = {56'd0, ld_shift[7:0]};
      F3_H:    rdata_o = {{48{ld_shift[15]}}, ld_shift[15:0]};
      F3_HU:   rdata_o = {48'd0, ld_shift[15:0]};
      F3_W:    rdata_o = {{32{ld_shift[31]}}, ld_shift[31:0]};
      F3_WU:   rdata_o = {32'd0, ld_shift[31:0]};
      F3_D:    rdata_o = ld_shift;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for MEM-stage load/store requests.
// One request at a time over valid/ready, WAIT_STATES extra cycles, then a
// response held until accepted. Storage is a doubleword array with a
// registered read and byte-enabled writes, accessed on the edge entering RESP.
// Optional feature macro DMEM_MISALIGN_ERR_EN: when defined, accesses whose
// address is not a multiple of the access size return rsp_err and never write.
import dmem_pkg::*;

module dmem_responder #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned AW    = IDX_W + 3;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        we_q;
  logic [AW-1:0] addr_q;
  logic [2:0]  funct3_q;
  logic [63:0] wdata_q;
  logic [63:0] rd_dword_q;
  logic [63:0] mem_q [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          mem_we;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [2:0]    acc_funct3;
  logic [63:0]   acc_wdata;
  logic [IDX_W-1:0] acc_idx;
  logic [7:0]    acc_be;
  logic [63:0]   acc_wdata_sh;
  logic [63:0]   ld_rdata;
  logic          acc_misalign;
  logic          acc_illegal;
  logic          acc_err;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^req_addr[63:AW];
  assign accept         = req_valid & req_ready;

  // In IDLE the access uses the live request (zero-wait stores write on the
  // accept edge); otherwise it uses the fields captured at accept.
  assign acc_we     = (state_q == IDLE) ? req_we              : we_q;
  assign acc_addr   = (state_q == IDLE) ? req_addr[AW-1:0]    : addr_q;
  assign acc_funct3 = (state_q == IDLE) ? req_funct3          : funct3_q;
  assign acc_wdata  = (state_q == IDLE) ? req_wdata           : wdata_q;
  assign acc_idx    = acc_addr[AW-1:3];

  dmem_lane_align u_lane_align (
    .we_i       (acc_we),
    .funct3_i   (acc_funct3),
    .addr_lo_i  (acc_addr[2:0]),
    .wdata_i    (acc_wdata),
    .rdword_i   (rd_dword_q),
    .be_o       (acc_be),
    .wdata_o    (acc_wdata_sh),
    .rdata_o    (ld_rdata),
    .misalign_o (acc_misalign),
    .illegal_o  (acc_illegal)
  );

`ifdef DMEM_MISALIGN_ERR_EN
  assign acc_err = acc_illegal | acc_misalign;
`else
  logic unused_misalign;
  assign unused_misalign = acc_misalign;
  assign acc_err         = acc_illegal;
`endif

  assign mem_we = enter_resp & acc_we & ~acc_err;

  // FSM state register; reset drops any in-flight request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Wait counter and request capture on the accept edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      funct3_q   <= '0;
      wdata_q    <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        we_q     <= req_we;
        addr_q   <= req_addr[AW-1:0];
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
      end
    end
  end

  // Next state, wait countdown and the storage-access strobe
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and response outputs, all derived from registered state
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: req_ready = rst;
      WAIT: busy = 1'b1;
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        rsp_err   = acc_err;
        if (!acc_we && !acc_err) rsp_rdata = ld_rdata;
      end
      default: ;
    endcase
  end

  // Storage: read-first registered read plus byte-enabled merge on entry to RESP
  always_ff @(posedge clk) begin
    if (enter_resp) begin
      rd_dword_q <= mem_q[acc_idx];
      if (mem_we) begin
        for (int b = 0; b < 8; b++) begin
          if (acc_be[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata_sh[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder. Three instances share
// clk/rst and differ only in WAIT_STATES (0, 3, 2); each has its own storage.
module tb_dmem_responder;

  localparam int N = 3;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] BAD = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_we     [N];
  logic [63:0] req_addr   [N];
  logic [2:0]  req_funct3 [N];
  logic [63:0] req_wdata  [N];
  logic        rsp_valid  [N];
  logic        rsp_ready  [N];
  logic [63:0] rsp_rdata  [N];
  logic        rsp_err    [N];
  logic        busy       [N];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int unsigned WS = (gi == 0) ? 0 : ((gi == 1) ? 3 : 2);
    dmem_responder #(.DEPTH(512), .WAIT_STATES(WS)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .req_we     (req_we[gi]),
      .req_addr   (req_addr[gi]),
      .req_funct3 (req_funct3[gi]),
      .req_wdata  (req_wdata[gi]),
      .rsp_valid  (rsp_valid[gi]),
      .rsp_ready  (rsp_ready[gi]),
      .rsp_rdata  (rsp_rdata[gi]),
      .rsp_err    (rsp_err[gi]),
      .busy       (busy[gi])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full request/response; request fields are scrambled after accept,
  // and the response is held for 'hold' cycles before rsp_ready.
  task automatic do_txn(input int d, input string tag, input logic we, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_funct3[d] = f3;
    req_wdata[d]  = wdata;
    check({tag, "/ready"}, 64'(req_ready[d]), 64'd1);
    @(posedge clk);
    #1;
    req_valid[d]  = 1'b0;
    req_we[d]     = ~we;
    req_addr[d]   = ~addr;
    req_funct3[d] = ~f3;
    req_wdata[d]  = ~wdata;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    if (rsp_valid[d]) begin
      check({tag, "/rdata"}, rsp_rdata[d], exp_rdata);
      check({tag, "/err"}, 64'(rsp_err[d]), 64'(exp_err));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "/hold_rdata"}, rsp_rdata[d], exp_rdata);
        check({tag, "/hold_valid"}, 64'(rsp_valid[d]), 64'd1);
        check({tag, "/hold_req_ready"}, 64'(req_ready[d]), 64'd0);
        check({tag, "/hold_busy"}, 64'(busy[d]), 64'd1);
      end
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[d] = 1'b0;
      @(negedge clk);
      check({tag, "/done_valid"}, 64'(rsp_valid[d]), 64'd0);
      check({tag, "/done_busy"}, 64'(busy[d]), 64'd0);
    end
    $display("[TB] txn dut%0d %s we=%0d f3=%0d addr=0x%0h wdata=0x%0h lat=%0d exp_rdata=0x%0h exp_err=%0d",
             d, tag, we, f3, addr, wdata, lat, exp_rdata, exp_err);
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < N; d++) begin
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'b0;
      req_addr[d]   = '0;
      req_funct3[d] = '0;
      req_wdata[d]  = '0;
      rsp_ready[d]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // 1: reset pulled low for 3 cycles while idle
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("rst%0d/req_ready", d), 64'(req_ready[d]), 64'd0);
      check($sformatf("rst%0d/rsp_valid", d), 64'(rsp_valid[d]), 64'd0);
      check($sformatf("rst%0d/busy", d), 64'(busy[d]), 64'd0);
      check($sformatf("rst%0d/rsp_rdata", d), rsp_rdata[d], 64'd0);
      check($sformatf("rst%0d/rsp_err", d), 64'(rsp_err[d]), 64'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      check($sformatf("rel%0d/req_ready", d), 64'(req_ready[d]), 64'd1);
      check($sformatf("rel%0d/busy", d), 64'(busy[d]), 64'd0);
    end

    // 2: zero wait states, doubleword store then load
    do_txn(0, "SD40", 1'b1, LD, 64'h40, 64'h1122334455667788, 64'd0, 1'b0, 1, 0);
    do_txn(0, "LD40", 1'b0, LD, 64'h40, 64'd0, 64'h1122334455667788, 1'b0, 1, 0);

    // 3: byte store merge and byte/half/word extraction with extension
    do_txn(0, "SB43", 1'b1, LB, 64'h43, 64'h00000000000000AB, 64'd0, 1'b0, 1, 0);
    do_txn(0, "LB43", 1'b0, LB, 64'h43, 64'd0, 64'hFFFFFFFFFFFFFFAB, 1'b0, 1, 0);
    do_txn(0, "LBU43", 1'b0, LBU, 64'h43, 64'd0, 64'h00000000000000AB, 1'b0, 1, 0);
    do_txn(0, "LD40m", 1'b0, LD, 64'h40, 64'd0, 64'h11223344AB667788, 1'b0, 1, 0);
    do_txn(0, "LW40", 1'b0, LW, 64'h40, 64'd0, 64'hFFFFFFFFAB667788, 1'b0, 1, 0);
    do_txn(0, "LWU40", 1'b0, LWU, 64'h40, 64'd0, 64'h00000000AB667788, 1'b0, 1, 0);
    do_txn(0, "LH46", 1'b0, LH, 64'h46, 64'd0, 64'h0000000000001122, 1'b0, 1, 0);
    do_txn(0, "LHU42", 1'b0, LHU, 64'h42, 64'd0, 64'h000000000000AB66, 1'b0, 1, 0);

    // 4: three wait states, response held 5 cycles without rsp_ready
    do_txn(1, "W3_SD40", 1'b1, LD, 64'h40, 64'h1122334455667788, 64'd0, 1'b0, 4, 0);
    do_txn(1, "W3_LW40", 1'b0, LW, 64'h40, 64'd0, 64'h0000000055667788, 1'b0, 4, 5);

    // 5: misaligned word load, illegal store and load encodings
`ifdef DMEM_MISALIGN_ERR_EN
    do_txn(1, "W3_LW42", 1'b0, LW, 64'h42, 64'd0, 64'd0, 1'b1, 4, 0);
`else
    do_txn(1, "W3_LW42", 1'b0, LW, 64'h42, 64'd0, 64'h0000000055667788, 1'b0, 4, 0);
`endif
    do_txn(1, "W3_SBAD", 1'b1, LBU, 64'h40, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, 4, 0);
    do_txn(1, "W3_LBAD", 1'b0, BAD, 64'h40, 64'd0, 64'd0, 1'b1, 4, 0);
    do_txn(1, "W3_LD40", 1'b0, LD, 64'h40, 64'd0, 64'h1122334455667788, 1'b0, 4, 0);

    // 6: address wrap, then a store killed by reset during WAIT
    do_txn(2, "W2_SD1000", 1'b1, LD, 64'h1000, 64'hDEAD, 64'd0, 1'b0, 3, 0);
    do_txn(2, "W2_LD0", 1'b0, LD, 64'h0, 64'd0, 64'hDEAD, 1'b0, 3, 0);
    @(negedge clk);
    req_valid[2]  = 1'b1;
    req_we[2]     = 1'b1;
    req_addr[2]   = 64'h0;
    req_funct3[2] = LD;
    req_wdata[2]  = 64'hBEEF;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("kill/busy_wait", 64'(busy[2]), 64'd1);
    rst = 1'b0;
    #1;
    check("kill/busy", 64'(busy[2]), 64'd0);
    check("kill/rsp_valid", 64'(rsp_valid[2]), 64'd0);
    check("kill/req_ready", 64'(req_ready[2]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("kill/rsp_valid_late", 64'(rsp_valid[2]), 64'd0);
    rst = 1'b1;
    $display("[TB] txn dut2 SD0_killed we=1 f3=3 addr=0x0 wdata=0xbeef reset during WAIT");
    do_txn(2, "W2_LD0_after", 1'b0, LD, 64'h0, 64'd0, 64'hDEAD, 1'b0, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
